value_to_segment_encoder: RTL and testbench
===========================================

# value_to_segment_encoder

Converts a 7-bit binary value (0-99) into two active-low seven-segment cathode patterns, one for the tens digit and one for the ones digit. It sits directly upstream of the two-digit display multiplexer and drives its `display_1` (ones, rightmost digit) and `display_2` (tens) inputs. Conversion is iterative double-dabble (shift-add-3) behind a valid/ready handshake. Results are held stable until the next accepted value.

## Interface
- `BLANK_LEADING_ZERO`, default 1: when 1, a tens digit of 0 is blanked.
- `clock` input 1: system clock (100 MHz); all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; asserts immediately and releases synchronously to `clock`.
- `value_valid` input 1: `value` is presented for conversion.
- `value` input 7: unsigned binary value to display.
- `value_ready` output 1: block is idle and accepts `value` on this edge.
- `display_1` output 7: ones-digit cathodes {a,b,c,d,e,f,g}, bit 6 = a, active-low.
- `display_2` output 7: tens-digit cathodes, same encoding.
- `update_done` output 1: one-cycle pulse when `display_1` and `display_2` have just updated.

## Operation
- FSM states:
  - IDLE: `value_ready`=1. If `value_valid`=1, latch `value`, clear the 8-bit BCD register, load shift count 7, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd, bin} left by 1. Decrement the count. At count 0, go to ENCODE.
  - ENCODE: register the segment patterns, pulse `update_done`, and go to IDLE.
- `value_valid` is ignored outside IDLE. Nothing is queued; the source must wait for `value_ready`.
- Out of range (latched value > 99): both outputs show a dash (1111110). Latency is unchanged, and all 7 SHIFT cycles still run.
- Digit patterns:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0000100
  - blank = 1111111
- Tens digit of 0 with `BLANK_LEADING_ZERO`=1: `display_2` = blank. The ones digit is never blanked, so value 0 shows " 0".
- BCD nibble values above 9 cannot occur for inputs ≤ 99. The decoder maps any nibble value above 9 to blank (defensive).

## Timing
- Reset values (reset low): state IDLE, `value_ready`=1, `display_1`=`display_2`=1111111, `update_done`=0, internal registers zeroed.
- Acceptance edge E0 (`value_valid` & `value_ready`): `value_ready` drops to 0 after E0.
- SHIFT operates on edges E1 through E7.
- ENCODE completes on edge E8:
  - Outputs change after E8.
  - `update_done`=1 for exactly the cycle following E8.
  - `value_ready`=1 again after E8.
- Latency is 8 cycles from acceptance to new outputs. Maximum throughput is one value per 9 cycles; back-to-back `value_valid` is accepted on E9.
- Between updates, outputs hold their previous pattern and never glitch mid-conversion.
- Reset asserted mid-conversion: abort immediately, blank both outputs, and drop `update_done`. The next acceptance is possible on the first edge after release.
- `update_done` and `value_ready` are both 1 in the cycle after E8. A new value may be accepted on that same edge (E9).

## Test plan
- Reset released, no stimulus: `value_ready`=1, both outputs 1111111, `update_done`=0 indefinitely.
- `value`=42 with valid for 1 cycle:
  - `value_ready` is low for 8 cycles.
  - After E8, `display_2`=1001100 and `display_1`=0010010.
  - `update_done` pulses once.
- Single-digit and zero values with `BLANK_LEADING_ZERO`=1:
  - `value`=7 gives `display_2`=1111111, `display_1`=0001111.
  - `value`=0 gives blank / 0000001.
  - With `BLANK_LEADING_ZERO`=0, `value`=7 gives `display_2`=0000001.
- Out-of-range values 100 and 127: both outputs 1111110 after 8 cycles. Then `value`=99 gives both outputs 0000100.
- `value_valid` held high with the value changing every cycle: only values present on acceptance edges (E0, E9, E18…) are converted, and intermediate values are ignored.
- Reset pulsed low at E4 of a conversion of 88:
  - Outputs blank immediately and there is no `update_done`.
  - After release, a conversion of 15 completes normally: 1001111 / 0100100.

Source files
------------

// File: rtl/value_to_segment_encoder_if.sv
// value_to_segment_encoder_if: handshake and display bus between a value source and the segment encoder
//   value_valid/value : source offers a 7-bit value
//   value_ready       : encoder is idle and takes the value on this edge
//   display_1/2       : active-low {a..g} cathodes, ones and tens digit
//   update_done       : one-cycle pulse after the displays change
interface value_to_segment_encoder_if;
    logic       value_valid;
    logic [6:0] value;
    logic       value_ready;
    logic [6:0] display_1;
    logic [6:0] display_2;
    logic       update_done;
    modport master (
        output value_valid, value,
        input  value_ready, display_1, display_2, update_done
    );
    modport slave (
        input  value_valid, value,
        output value_ready, display_1, display_2, update_done
    );
endinterface

// File: rtl/value_to_segment_encoder.sv
// value_to_segment_encoder: 0-99 binary to two active-low seven-segment digits via iterative double-dabble
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of value_to_segment_encoder_if (valid/ready in, digit patterns and done pulse out)
module value_to_segment_encoder #(
    parameter bit BLANK_LEADING_ZERO = 1'b1
) (
    input  logic                            clock,
    input  logic                            reset,
    value_to_segment_encoder_if.slave       bus
);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b1111110;
    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;
    state_t      state_q, state_d;
    logic [6:0]  bin_q, bin_d;
    logic [7:0]  bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        oor_q, oor_d;
    logic [6:0]  disp1_q, disp1_d;
    logic [6:0]  disp2_q, disp2_d;
    logic        done_q, done_d;
    logic [7:0]  adj;
    logic [14:0] sh;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = BLANK;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        disp1_d = disp1_q;
        disp2_d = disp2_q;
        done_d  = 1'b0;
        // add-3 correction happens before the shift so each nibble stays a legal BCD digit afterwards
        adj = {(bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
               (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
        sh  = {adj, bin_q} << 1;
        case (state_q)
            IDLE: if (bus.value_valid) begin
                bin_d   = bus.value;
                oor_d   = bus.value > 7'd99;
                bcd_d   = '0;
                cnt_d   = 3'd7;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d   = sh[14:7];
                bin_d   = sh[6:0];
                cnt_d   = cnt_q - 3'd1;
                state_d = (cnt_q == 3'd1) ? ENCODE : SHIFT;
            end
            ENCODE: begin
                disp1_d = oor_q ? DASH : seg(bcd_q[3:0]);
                disp2_d = oor_q ? DASH :
                          (BLANK_LEADING_ZERO && bcd_q[7:4] == 4'd0) ? BLANK : seg(bcd_q[7:4]);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            oor_q   <= 1'b0;
            disp1_q <= BLANK;
            disp2_q <= BLANK;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
            disp1_q <= disp1_d;
            disp2_q <= disp2_d;
            done_q  <= done_d;
        end
    end

    assign bus.value_ready = (state_q == IDLE);
    assign bus.display_1   = disp1_q;
    assign bus.display_2   = disp2_q;
    assign bus.update_done = done_q;
endmodule

// File: tb/tb_value_to_segment_encoder.sv
// tb_value_to_segment_encoder: directed checks of the segment encoder with and without leading-zero blanking
module tb_value_to_segment_encoder;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b1111110;
    logic clock;
    logic reset;
    int   tests;
    int   fails;
    value_to_segment_encoder_if ia();
    value_to_segment_encoder_if ib();
    value_to_segment_encoder #(.BLANK_LEADING_ZERO(1'b1)) dut_a (.clock(clock), .reset(reset), .bus(ia));
    value_to_segment_encoder #(.BLANK_LEADING_ZERO(1'b0)) dut_b (.clock(clock), .reset(reset), .bus(ib));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] val);
        ia.value_valid = v;
        ia.value       = val;
        ib.value_valid = v;
        ib.value       = val;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ia.value_ready && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_ready_wait"}, ia.value_ready, 1);
    endtask

    task automatic conv(input string tag, input logic [6:0] v, input logic [6:0] e1,
                        input logic [6:0] e2a, input logic [6:0] e2b);
        int         lows;
        logic [6:0] h1, h2;
        wait_ready(tag);
        h1 = ia.display_1;
        h2 = ia.display_2;
        @(negedge clock);
        drive(1'b1, v);
        @(posedge clock);
        #1;
        drive(1'b0, 7'd0);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            if (!ia.value_ready && !ia.update_done && ia.display_1 == h1 && ia.display_2 == h2)
                lows++;
            if (i < 7) begin
                @(posedge clock);
                #1;
            end
        end
        check({tag, "_busy_cycles"}, lows, 8);
        @(posedge clock);
        #1;
        check({tag, "_done"}, ia.update_done, 1);
        check({tag, "_ready"}, ia.value_ready, 1);
        check({tag, "_ones_a"}, ia.display_1, e1);
        check({tag, "_tens_a"}, ia.display_2, e2a);
        check({tag, "_ones_b"}, ib.display_1, e1);
        check({tag, "_tens_b"}, ib.display_2, e2b);
        @(posedge clock);
        #1;
        check({tag, "_done_drop"}, ia.update_done, 0);
    endtask

    initial begin
        int cnt;
        logic [6:0] seq;
        tests = 0;
        fails = 0;
        clock = 0;
        reset = 0;
        drive(1'b0, 7'd0);
        #23;
        check("rst_ready", ia.value_ready, 1);
        check("rst_ones", ia.display_1, BLANK);
        check("rst_tens", ia.display_2, BLANK);
        check("rst_done", ia.update_done, 0);
        @(negedge clock);
        reset = 1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (ia.value_ready && !ia.update_done && ia.display_1 == BLANK && ia.display_2 == BLANK)
                cnt++;
        end
        check("idle_hold", cnt, 6);

        conv("v42", 7'd42, 7'b0010010, 7'b1001100, 7'b1001100);
        conv("v7", 7'd7, 7'b0001111, BLANK, 7'b0000001);
        conv("v0", 7'd0, 7'b0000001, BLANK, 7'b0000001);
        conv("v100", 7'd100, DASH, DASH, DASH);
        conv("v127", 7'd127, DASH, DASH, DASH);
        conv("v99", 7'd99, 7'b0000100, 7'b0000100, 7'b0000100);

        // valid held high, value changing every cycle: only edges 0 and 9 accept
        wait_ready("b2b");
        for (int k = 0; k < 18; k++) begin
            @(negedge clock);
            seq = 7'(10 + 3 * k);
            drive(1'b1, seq);
            @(posedge clock);
            #1;
            if (k == 8) begin
                check("b2b_first_done", ia.update_done, 1);
                check("b2b_first_ready", ia.value_ready, 1);
                check("b2b_first_ones", ia.display_1, 7'b0000001);
                check("b2b_first_tens", ia.display_2, 7'b1001111);
            end
            if (k == 17) begin
                check("b2b_second_done", ia.update_done, 1);
                check("b2b_second_ones", ia.display_1, 7'b0001111);
                check("b2b_second_tens", ia.display_2, 7'b0000110);
            end
        end
        @(negedge clock);
        drive(1'b0, 7'd0);

        // reset during a conversion of 88
        wait_ready("rst88");
        @(negedge clock);
        drive(1'b1, 7'd88);
        @(posedge clock);
        #1;
        drive(1'b0, 7'd0);
        repeat (4) @(posedge clock);
        #1;
        reset = 0;
        #1;
        check("midrst_ones", ia.display_1, BLANK);
        check("midrst_tens", ia.display_2, BLANK);
        check("midrst_done", ia.update_done, 0);
        check("midrst_ready", ia.value_ready, 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (ia.update_done || ia.display_1 != BLANK)
                cnt++;
        end
        check("midrst_no_done", cnt, 0);
        conv("v15", 7'd15, 7'b0100100, 7'b1001111, 7'b1001111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
